if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID stage.
- Owns the PC register and the IF/ID pipeline register.
- Obeys the hazard detector's pcWrite / IF2ID_write / IF2ID_flush controls and the MEM-stage branch/jump redirect.
- Talks to instruction memory over a variable-latency req/ack handshake.

---
 rtl/if_fetch_stage.sv | 153 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, follows hazard-unit
// stall/flush controls and MEM-stage redirects, and fetches over a req/ack port.
module if_fetch_stage #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_write_i,
  input  logic              if2id_write_i,
  input  logic              if2id_flush_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] if_id_pc4_o,
  output logic [31:0]       if_id_instr_o,
  output logic              if_id_valid_o,
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [31:0]       buf_q, buf_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;

  logic              ack;
  logic              advance;
  logic [ADDR_W-1:0] pc_plus4;

  // Handshake: imem_req_o and imem_addr_o stay stable until a cycle with
  // imem_ack_i=1; that cycle carries imem_rdata_i. An ack while req is low is ignored.
  assign ack      = imem_ack_i & req_q;
  assign advance  = pc_write_i & if2id_write_i;
  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    buf_d     = buf_q;
    pc4_d     = pc4_q;
    instr_d   = instr_q;
    valid_d   = valid_q;

    case (state_q)
      ST_FETCH: begin
        if (redirect_i) begin
          if (ack) begin
            pc_d = redirect_pc_i;
          end else begin
            pend_pc_d = redirect_pc_i;
            state_d   = ST_DROP;
          end
          if (if2id_write_i) begin
            pc4_d = '0; instr_d = '0; valid_d = 1'b0;
          end
        end else if (ack && advance) begin
          pc4_d   = pc_plus4;
          instr_d = imem_rdata_i;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end else if (ack) begin
          buf_d   = imem_rdata_i;
          state_d = ST_HOLD;
          if (if2id_write_i) begin
            pc4_d = '0; instr_d = '0; valid_d = 1'b0;
          end
        end else if (if2id_write_i) begin
          pc4_d = '0; instr_d = '0; valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          buf_d   = '0;
          pc_d    = redirect_pc_i;
          state_d = ST_FETCH;
          if (if2id_write_i) begin
            pc4_d = '0; instr_d = '0; valid_d = 1'b0;
          end
        end else if (advance) begin
          pc4_d   = pc_plus4;
          instr_d = buf_q;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          state_d = ST_FETCH;
        end else if (if2id_write_i) begin
          pc4_d = '0; instr_d = '0; valid_d = 1'b0;
        end
      end
      ST_DROP: begin
        // The outstanding request completes at the old address; its data is thrown away.
        if (redirect_i) pend_pc_d = redirect_pc_i;
        if (ack) begin
          pc_d    = redirect_i ? redirect_pc_i : pend_pc_q;
          state_d = ST_FETCH;
        end
        if (if2id_write_i) begin
          pc4_d = '0; instr_d = '0; valid_d = 1'b0;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    if (if2id_flush_i) begin
      pc4_d = '0; instr_d = '0; valid_d = 1'b0;
    end

    req_d = (state_d != ST_HOLD);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      buf_q     <= '0;
      req_q     <= 1'b0;
      pc4_q     <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      buf_q     <= buf_d;
      req_q     <= req_d;
      pc4_q     <= pc4_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_instr_o = instr_q;
  assign if_id_valid_o = valid_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: per-cycle vector table with a queue of expected
// outputs, plus a second instance covering PC wrap and asynchronous reset.
module tb_if_fetch_stage;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } out_t;

  typedef struct packed {
    logic [3:0]  ctl;   // {pc_write, if2id_write, flush, redirect}
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b1, if2id_write = 1'b1, flush = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        req;
  logic [31:0] addr, pc, pc4, instr;
  logic        valid;
  logic [1:0]  dbg_state;

  logic        b_rst_n = 1'b0, b_redirect = 1'b0, b_ack = 1'b0;
  logic [31:0] b_redirect_pc = '0, b_rdata = '0;
  logic        b_req, b_valid;
  logic [31:0] b_addr, b_pc, b_pc4, b_instr;
  logic [1:0]  b_dbg_state;

  out_t exp_q[$];
  vec_t tbl[30];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .pc_write_i(pc_write), .if2id_write_i(if2id_write), .if2id_flush_i(flush),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
    .pc_o(pc), .if_id_pc4_o(pc4), .if_id_instr_o(instr), .if_id_valid_o(valid),
    .dbg_state_o(dbg_state)
  );

  if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(b_rst_n),
    .pc_write_i(1'b1), .if2id_write_i(1'b1), .if2id_flush_i(1'b0),
    .redirect_i(b_redirect), .redirect_pc_i(b_redirect_pc),
    .imem_req_o(b_req), .imem_addr_o(b_addr), .imem_ack_i(b_ack), .imem_rdata_i(b_rdata),
    .pc_o(b_pc), .if_id_pc4_o(b_pc4), .if_id_instr_o(b_instr), .if_id_valid_o(b_valid),
    .dbg_state_o(b_dbg_state)
  );

  function automatic vec_t mkv(input logic [3:0] ctl, input logic [31:0] rpc,
                               input logic a, input logic [31:0] rd,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic [31:0] e_pc, input logic [31:0] e_pc4,
                               input logic [31:0] e_instr, input logic e_valid);
    vec_t v;
    v.ctl = ctl; v.rpc = rpc; v.ack = a; v.rdata = rd;
    v.exp.req = e_req; v.exp.addr = e_addr; v.exp.pc = e_pc;
    v.exp.pc4 = e_pc4; v.exp.instr = e_instr; v.exp.valid = e_valid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cmp_out(input string tag, input out_t act);
    out_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".req"},   32'(act.req),   32'(e.req));
    chk({tag, ".addr"},  act.addr,       e.addr);
    chk({tag, ".pc"},    act.pc,         e.pc);
    chk({tag, ".pc4"},   act.pc4,        e.pc4);
    chk({tag, ".instr"}, act.instr,      e.instr);
    chk({tag, ".valid"}, 32'(act.valid), 32'(e.valid));
  endtask

  function automatic out_t dut_out();
    return '{req, addr, pc, pc4, instr, valid};
  endfunction

  function automatic out_t wrap_out();
    return '{b_req, b_addr, b_pc, b_pc4, b_instr, b_valid};
  endfunction

  initial begin
    // Run: pw,iw set; stall: neither; flush/redirect bits as named.
    tbl[0]  = mkv(4'b1100, 0, 0, 0,              1, 'h0,   'h0,   0,     0,            0);
    tbl[1]  = mkv(4'b1100, 0, 1, 32'h2001_0005,  1, 'h4,   'h4,   'h4,   32'h2001_0005, 1);
    tbl[2]  = mkv(4'b1100, 0, 1, 32'h2002_0007,  1, 'h8,   'h8,   'h8,   32'h2002_0007, 1);
    tbl[3]  = mkv(4'b0000, 0, 1, 32'h2003_0009,  0, 'h8,   'h8,   'h8,   32'h2002_0007, 1);
    tbl[4]  = mkv(4'b1100, 0, 0, 0,              1, 'hC,   'hC,   'hC,   32'h2003_0009, 1);
    tbl[5]  = mkv(4'b1100, 0, 1, 32'h2004_000B,  1, 'h10,  'h10,  'h10,  32'h2004_000B, 1);
    tbl[6]  = mkv(4'b1111, 'h40, 0, 0,           1, 'h10,  'h10,  0,     0,            0);
    tbl[7]  = mkv(4'b1100, 0, 0, 0,              1, 'h10,  'h10,  0,     0,            0);
    tbl[8]  = mkv(4'b1100, 0, 1, 32'hDEAD_BEEF,  1, 'h40,  'h40,  0,     0,            0);
    tbl[9]  = mkv(4'b1100, 0, 1, 32'h2005_0001,  1, 'h44,  'h44,  'h44,  32'h2005_0001, 1);
    tbl[10] = mkv(4'b1101, 'h40, 0, 0,           1, 'h44,  'h44,  0,     0,            0);
    tbl[11] = mkv(4'b1101, 'h80, 0, 0,           1, 'h44,  'h44,  0,     0,            0);
    tbl[12] = mkv(4'b1100, 0, 1, 32'hBAD0_0001,  1, 'h80,  'h80,  0,     0,            0);
    tbl[13] = mkv(4'b1101, 'h100, 1, 32'hBAD0_0002, 1, 'h100, 'h100, 0,  0,            0);
    tbl[14] = mkv(4'b1100, 0, 1, 32'h2006_0002,  1, 'h104, 'h104, 'h104, 32'h2006_0002, 1);
    tbl[15] = mkv(4'b0000, 0, 1, 32'h2007_0003,  0, 'h104, 'h104, 'h104, 32'h2006_0002, 1);
    tbl[16] = mkv(4'b0000, 0, 1, 32'hBAD0_0003,  0, 'h104, 'h104, 'h104, 32'h2006_0002, 1);
    tbl[17] = mkv(4'b1100, 0, 0, 0,              1, 'h108, 'h108, 'h108, 32'h2007_0003, 1);
    tbl[18] = mkv(4'b1000, 0, 1, 32'h2008_0004,  0, 'h108, 'h108, 'h108, 32'h2007_0003, 1);
    tbl[19] = mkv(4'b1100, 0, 0, 0,              1, 'h10C, 'h10C, 'h10C, 32'h2008_0004, 1);
    tbl[20] = mkv(4'b0100, 0, 1, 32'h2009_0005,  0, 'h10C, 'h10C, 0,     0,            0);
    tbl[21] = mkv(4'b1100, 0, 0, 0,              1, 'h110, 'h110, 'h110, 32'h2009_0005, 1);
    tbl[22] = mkv(4'b1110, 0, 1, 32'h200A_0006,  1, 'h114, 'h114, 0,     0,            0);
    tbl[23] = mkv(4'b1100, 0, 1, 32'h200B_0007,  1, 'h118, 'h118, 'h118, 32'h200B_0007, 1);
    tbl[24] = mkv(4'b0000, 0, 0, 0,              1, 'h118, 'h118, 'h118, 32'h200B_0007, 1);
    tbl[25] = mkv(4'b0000, 0, 1, 32'h200C_0008,  0, 'h118, 'h118, 'h118, 32'h200B_0007, 1);
    tbl[26] = mkv(4'b1101, 'h300, 0, 0,          1, 'h300, 'h300, 0,     0,            0);
    tbl[27] = mkv(4'b1100, 0, 1, 32'h200D_0009,  1, 'h304, 'h304, 'h304, 32'h200D_0009, 1);
    tbl[28] = mkv(4'b1101, 'h400, 0, 0,          1, 'h304, 'h304, 0,     0,            0);
    tbl[29] = mkv(4'b1101, 'h500, 1, 32'hBAD0_0004, 1, 'h500, 'h500, 0,  0,            0);

    // Reset state of both instances
    repeat (2) @(negedge clk);
    chk("rst.req",   32'(req),   0);
    chk("rst.pc",    pc,         0);
    chk("rst.pc4",   pc4,        0);
    chk("rst.instr", instr,      0);
    chk("rst.valid", 32'(valid), 0);
    chk("rst.wrap_pc", b_pc, 32'hFFFF_FFFC);
    chk("rst.wrap_req", 32'(b_req), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      {pc_write, if2id_write, flush, redirect} = tbl[i].ctl;
      redirect_pc = tbl[i].rpc;
      ack = tbl[i].ack;
      rdata = tbl[i].rdata;
      exp_q.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      cmp_out($sformatf("vec%0d", i), dut_out());
    end
    @(negedge clk);
    {pc_write, if2id_write, flush, redirect} = 4'b1100;
    ack = 1'b0;

    // PC wrap, then asynchronous reset while in DROP
    @(negedge clk);
    b_rst_n = 1'b1;
    exp_q.push_back('{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0});
    @(posedge clk); #1;
    cmp_out("wrap.start", wrap_out());

    @(negedge clk);
    b_ack = 1'b1; b_rdata = 32'h1234_5678;
    exp_q.push_back('{1'b1, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 1'b1});
    @(posedge clk); #1;
    cmp_out("wrap.fetch", wrap_out());

    @(negedge clk);
    b_ack = 1'b0; b_redirect = 1'b1; b_redirect_pc = 32'h40;
    exp_q.push_back('{1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0});
    @(posedge clk); #1;
    cmp_out("wrap.drop", wrap_out());
    chk("wrap.drop_state", 32'(b_dbg_state), 32'd2);

    @(negedge clk);
    b_redirect = 1'b0;
    #2 b_rst_n = 1'b0;
    #1;
    exp_q.push_back('{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0});
    cmp_out("async_rst", wrap_out());
    chk("async_rst.state", 32'(b_dbg_state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
